// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, ALU control encodings and the ID/EX register layout.
package riscv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int CTRL_WIDTH = 4;
  typedef enum logic [CTRL_WIDTH-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001,
    ALU_LUI  = 4'b1111
  } alu_op_e;
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  alu_src;
    logic                  op1_pc;
    logic [CTRL_WIDTH-1:0] alu_ctrl;
    logic [ADDR_WIDTH-1:0] rd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc;
  } id_ex_t;
endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if: decode-side inputs, bypass buses and ALU-side outputs of the ID/EX stage.
interface id_ex_operand_stage_if;
  import riscv_pkg::*;
  logic                  valid_in, alu_src_in, op1_pc_in, mem_read_in, reg_write_in;
  logic                  stall_in, flush_in;
  logic [DATA_WIDTH-1:0] rd1_in, rd2_in, imm_in, pc_in;
  logic [ADDR_WIDTH-1:0] rs1_in, rs2_in, rd_in;
  logic [CTRL_WIDTH-1:0] alu_ctrl_in;
  logic                  exm_we, mwb_we;
  logic [ADDR_WIDTH-1:0] exm_rd, mwb_rd;
  logic [DATA_WIDTH-1:0] exm_res, mwb_res;
  logic [DATA_WIDTH-1:0] op1, op2, store_data, pc_out;
  logic [CTRL_WIDTH-1:0] alu_ctrl_out;
  logic [ADDR_WIDTH-1:0] rd_out;
  logic                  reg_write_out, mem_read_out, valid_out, hazard_stall;
  modport master (
    output valid_in, alu_src_in, op1_pc_in, mem_read_in, reg_write_in, stall_in, flush_in,
           rd1_in, rd2_in, imm_in, pc_in, rs1_in, rs2_in, rd_in, alu_ctrl_in,
           exm_we, mwb_we, exm_rd, mwb_rd, exm_res, mwb_res,
    input  op1, op2, store_data, pc_out, alu_ctrl_out, rd_out,
           reg_write_out, mem_read_out, valid_out, hazard_stall
  );
  modport slave (
    input  valid_in, alu_src_in, op1_pc_in, mem_read_in, reg_write_in, stall_in, flush_in,
           rd1_in, rd2_in, imm_in, pc_in, rs1_in, rs2_in, rd_in, alu_ctrl_in,
           exm_we, mwb_we, exm_rd, mwb_rd, exm_res, mwb_res,
    output op1, op2, store_data, pc_out, alu_ctrl_out, rd_out,
           reg_write_out, mem_read_out, valid_out, hazard_stall
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// fwd_mux: priority bypass select for one source operand; x0 reads zero, EX/MEM beats MEM/WB.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0] reg_val,
  input  logic                  exm_we,
  input  logic [ADDR_WIDTH-1:0] exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_res,
  input  logic                  mwb_we,
  input  logic [ADDR_WIDTH-1:0] mwb_rd,
  input  logic [DATA_WIDTH-1:0] mwb_res,
  output logic [DATA_WIDTH-1:0] val
);
  always_comb begin
    val = (src == '0) ? '0 :
          (exm_we && exm_rd == src) ? exm_res :
          (mwb_we && mwb_rd == src) ? mwb_res : reg_val;
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand forwarding and load-use bubble insertion.
module id_ex_operand_stage
  import riscv_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);
  id_ex_t                st_q, st_d;
  logic                  hazard;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;
  // A load sitting in this stage cannot feed a dependent instruction in decode.
  always_comb begin
    hazard = !bus.flush_in && st_q.valid && st_q.mem_read && st_q.rd != '0 && bus.valid_in &&
             (st_q.rd == bus.rs1_in || st_q.rd == bus.rs2_in);
  end
  always_comb begin
    st_d = st_q;
    if (bus.flush_in || (!bus.stall_in && hazard)) begin
      st_d.valid     = 1'b0;
      st_d.reg_write = 1'b0;
      st_d.mem_read  = 1'b0;
    end else if (!bus.stall_in) begin
      st_d = '{valid: bus.valid_in, reg_write: bus.valid_in & bus.reg_write_in,
               mem_read: bus.valid_in & bus.mem_read_in, alu_src: bus.alu_src_in,
               op1_pc: bus.op1_pc_in, alu_ctrl: bus.alu_ctrl_in, rd: bus.rd_in,
               rs1: bus.rs1_in, rs2: bus.rs2_in, rd1: bus.rd1_in, rd2: bus.rd2_in,
               imm: bus.imm_in, pc: bus.pc_in};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) st_q <= '0;
    else st_q <= st_d;
  end
  fwd_mux u_fwd1 (
    .src(st_q.rs1), .reg_val(st_q.rd1),
    .exm_we(bus.exm_we), .exm_rd(bus.exm_rd), .exm_res(bus.exm_res),
    .mwb_we(bus.mwb_we), .mwb_rd(bus.mwb_rd), .mwb_res(bus.mwb_res),
    .val(fwd1)
  );
  fwd_mux u_fwd2 (
    .src(st_q.rs2), .reg_val(st_q.rd2),
    .exm_we(bus.exm_we), .exm_rd(bus.exm_rd), .exm_res(bus.exm_res),
    .mwb_we(bus.mwb_we), .mwb_rd(bus.mwb_rd), .mwb_res(bus.mwb_res),
    .val(fwd2)
  );
  assign bus.op1           = st_q.op1_pc ? st_q.pc : fwd1;
  assign bus.op2           = st_q.alu_src ? st_q.imm : fwd2;
  assign bus.store_data    = fwd2;
  assign bus.alu_ctrl_out  = st_q.alu_ctrl;
  assign bus.rd_out        = st_q.rd;
  assign bus.reg_write_out = st_q.reg_write;
  assign bus.mem_read_out  = st_q.mem_read;
  assign bus.pc_out        = st_q.pc;
  assign bus.valid_out     = st_q.valid;
  assign bus.hazard_stall  = hazard;
endmodule
